// File: rtl/cpu_pkg.sv
// Shared constants for the CPU front end: instruction field widths,
// opcode values, the idle instruction and the sequencer state encoding.
package cpu_pkg;

    localparam int OP_SIZE  = 4;
    localparam int ARG_SIZE = 3;
    localparam int ARG_NUM  = 2;
    localparam int INSTR_W  = OP_SIZE + ARG_NUM * ARG_SIZE;

    localparam logic [OP_SIZE-1:0] OP_LOAD = 4'd0;
    localparam logic [OP_SIZE-1:0] OP_MOVE = 4'd1;
    localparam logic [OP_SIZE-1:0] OP_ADD  = 4'd2;
    localparam logic [OP_SIZE-1:0] OP_XOR  = 4'd3;
    localparam logic [OP_SIZE-1:0] OP_NOP  = 4'd14;
    localparam logic [OP_SIZE-1:0] OP_HALT = 4'd15;

    // Presented to the control FSM whenever no instruction is live.
    localparam logic [INSTR_W-1:0] IDLE_INSTR = {OP_NOP, {(ARG_NUM * ARG_SIZE){1'b0}}};

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_HALTED = 3'd4
    } seq_state_t;

    // Opcodes that need the control FSM to run an execute phase.
    function automatic logic is_exec_op(input logic [OP_SIZE-1:0] op);
        return (op == OP_LOAD) || (op == OP_MOVE) || (op == OP_ADD) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/instr_sequencer_exec_watchdog.sv
// Execute-phase watchdog: a down-counter loaded on clr, decremented while
// en is high, expiring on the TIMEOUT-th enabled cycle after a clear.
module exec_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count reached while still enabled means the limit is used up.
    assign expire = en && (cnt_q == '0);

    // Next count: reload on clear, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = TC_LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= TC_LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue sequencer in front of the CPU control FSM.
//
// state  | meaning
// IDLE   | stopped, waiting for start (pc_clr allowed)
// FETCH  | mem_req high at pc, waiting for mem_ack
// DECODE | one cycle classifying the fetched opcode
// EXEC   | instruction presented, waiting for exec_done (watchdog running)
// HALTED | HALT decoded or watchdog expired, waiting for start
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop_req,
    input  logic               pc_clr,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               pc_load,
    input  logic [PC_W-1:0]    pc_load_val,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               illegal_op,
    output logic               timeout
);

    seq_state_t         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic               mem_req_q, mem_req_d;
    logic               stop_pend_q, stop_pend_d;
    logic               illegal_op_q, illegal_op_d;
    logic               timeout_q, timeout_d;

    logic               is_busy;
    logic               wdt_expire;
    logic [OP_SIZE-1:0] op;

    assign is_busy = (state_q == SEQ_FETCH) || (state_q == SEQ_DECODE) || (state_q == SEQ_EXEC);
    assign op      = ir_q[INSTR_W-1 -: OP_SIZE];

    exec_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == SEQ_DECODE),
        .en     (state_q == SEQ_EXEC),
        .expire (wdt_expire)
    );

    // Next-state, PC and output computation; every output leaves a flop.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        mem_req_d     = mem_req_q;
        stop_pend_d   = stop_pend_q;
        illegal_op_d  = 1'b0;
        timeout_d     = 1'b0;

        if (is_busy && stop_req) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            SEQ_IDLE, SEQ_HALTED: begin
                if (pc_clr) begin
                    pc_d = '0;
                end
                if (start) begin
                    state_d   = SEQ_FETCH;
                    mem_req_d = 1'b1;
                end
            end

            SEQ_FETCH: begin
                if (mem_ack) begin
                    ir_d      = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = SEQ_DECODE;
                end
            end

            SEQ_DECODE: begin
                if (is_exec_op(op)) begin
                    state_d       = SEQ_EXEC;
                    instr_d       = ir_q;
                    instr_valid_d = 1'b1;
                end else if (op == OP_HALT) begin
                    state_d     = SEQ_HALTED;
                    stop_pend_d = 1'b0;
                end else begin
                    pc_d         = pc_q + 1'b1;
                    illegal_op_d = (op != OP_NOP);
                    // Instruction boundary: a pending stop parks in IDLE.
                    if (stop_pend_q || stop_req) begin
                        state_d     = SEQ_IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d   = SEQ_FETCH;
                        mem_req_d = 1'b1;
                    end
                end
            end

            SEQ_EXEC: begin
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (exec_done) begin
                    pc_d          = pc_load ? pc_load_val : (pc_q + 1'b1);
                    instr_d       = IDLE_INSTR;
                    instr_valid_d = 1'b0;
                    if (stop_pend_q || stop_req) begin
                        state_d     = SEQ_IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d   = SEQ_FETCH;
                        mem_req_d = 1'b1;
                    end
                end else if (wdt_expire) begin
                    timeout_d     = 1'b1;
                    instr_d       = IDLE_INSTR;
                    instr_valid_d = 1'b0;
                    state_d       = SEQ_HALTED;
                    stop_pend_d   = 1'b0;
                end
            end

            default: begin
                state_d       = SEQ_IDLE;
                instr_d       = IDLE_INSTR;
                instr_valid_d = 1'b0;
                mem_req_d     = 1'b0;
            end
        endcase
    end

    // Sequencer registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= SEQ_IDLE;
            pc_q          <= '0;
            ir_q          <= IDLE_INSTR;
            instr_q       <= IDLE_INSTR;
            instr_valid_q <= 1'b0;
            mem_req_q     <= 1'b0;
            stop_pend_q   <= 1'b0;
            illegal_op_q  <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            mem_req_q     <= mem_req_d;
            stop_pend_q   <= stop_pend_d;
            illegal_op_q  <= illegal_op_d;
            timeout_q     <= timeout_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign busy        = is_busy;
    assign halted      = (state_q == SEQ_HALTED);
    assign illegal_op  = illegal_op_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with simple memory and control-FSM responders.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop_req = 1'b0;
    logic       pc_clr = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [9:0] mem_rdata = '0;
    logic [9:0] instr;
    logic       instr_valid;
    logic       exec_done = 1'b0;
    logic       pc_load = 1'b0;
    logic [7:0] pc_load_val = '0;
    logic [7:0] pc;
    logic       busy;
    logic       halted;
    logic       illegal_op;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    // responder settings
    logic [9:0] mem [256];
    int         ack_delay  = 1;
    int         exec_delay = 1;
    bit         exec_en    = 1'b1;
    bit         load_en    = 1'b0;
    logic [7:0] load_pc    = '0;
    logic [7:0] load_val   = '0;
    logic [7:0] wait_addr  = '0;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop_req    (stop_req),
        .pc_clr      (pc_clr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .timeout     (timeout)
    );

    initial forever #5 clk = ~clk;

    // Program memory: ack after ack_delay cycles of mem_req.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    mem_ack = 1'b0;
                end
                cnt++;
            end else begin
                cnt     = 0;
                mem_ack = 1'b0;
            end
        end
    end

    // Control FSM: exec_done exec_delay cycles after instr_valid rises.
    initial begin
        int ecnt;
        ecnt = 0;
        forever begin
            @(negedge clk);
            pc_load_val = load_val;
            if (instr_valid) begin
                if (exec_en && ecnt == exec_delay) begin
                    exec_done = 1'b1;
                    pc_load   = load_en && (pc == load_pc);
                end else begin
                    exec_done = 1'b0;
                    pc_load   = 1'b0;
                end
                ecnt++;
            end else begin
                ecnt      = 0;
                exec_done = 1'b0;
                pc_load   = 1'b0;
            end
        end
    end

    task automatic wait_for(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            case (which)
                0: ok = mem_req;
                1: ok = instr_valid;
                2: ok = !instr_valid;
                3: ok = halted;
                4: ok = !busy;
                default: ok = mem_req && (mem_addr == wait_addr);
            endcase
            if (ok) return;
            @(negedge clk);
        end
    endtask

    task automatic pulse_start(input bit clr);
        @(negedge clk);
        start  = 1'b1;
        pc_clr = clr;
        @(negedge clk);
        start  = 1'b0;
        pc_clr = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        @(negedge clk);
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
        checks++; if (instr !== 10'h380) begin errors++; $display("FAIL reset_instr got=%h exp=380", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if ({busy, halted, illegal_op, timeout} !== 4'b0000)
            begin errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, halted, illegal_op, timeout}); end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({busy, mem_req} !== 2'b00) begin errors++; $display("FAIL idle_after_reset got=%b exp=00", {busy, mem_req}); end
    endtask

    task automatic test_basic;
        bit ok;
        mem[0] = 10'h008;
        mem[1] = 10'h3C0;
        ack_delay = 1; exec_delay = 2; exec_en = 1'b1; load_en = 1'b0;
        @(negedge clk); pc_clr = 1'b1; @(negedge clk); pc_clr = 1'b0;
        pulse_start(1'b0);
        wait_for(0, 20, ok);
        checks++; if (!ok || mem_addr !== 8'h00) begin errors++; $display("FAIL basic_fetch0 ok=%b addr=%h exp=00", ok, mem_addr); end
        wait_for(1, 20, ok);
        checks++; if (!ok || instr !== 10'h008) begin errors++; $display("FAIL basic_instr ok=%b got=%h exp=008", ok, instr); end
        wait_for(2, 20, ok);
        checks++; if (!ok || pc !== 8'h01) begin errors++; $display("FAIL basic_pc_inc ok=%b got=%h exp=01", ok, pc); end
        checks++; if (instr !== 10'h380) begin errors++; $display("FAIL basic_instr_idle got=%h exp=380", instr); end
        wait_for(3, 30, ok);
        checks++; if (!ok || pc !== 8'h01 || busy !== 1'b0) begin errors++; $display("FAIL basic_halt ok=%b pc=%h busy=%b exp pc=01 busy=0", ok, pc, busy); end
    endtask

    task automatic test_jump;
        bit ok;
        int vcnt;
        mem[0] = 10'h0AB;
        mem[1] = 10'h3C0;
        mem[8'h40] = 10'h3C0;
        exec_delay = 3; load_en = 1'b1; load_pc = 8'h00; load_val = 8'h40;
        pulse_start(1'b1);
        wait_for(1, 30, ok);
        checks++; if (!ok || instr !== 10'h0AB) begin errors++; $display("FAIL jump_instr ok=%b got=%h exp=0AB", ok, instr); end
        vcnt = 0;
        while (instr_valid && vcnt < 50) begin vcnt++; @(negedge clk); end
        checks++; if (vcnt != 4) begin errors++; $display("FAIL jump_valid_len got=%0d exp=4", vcnt); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h40) begin errors++; $display("FAIL jump_addr req=%b addr=%h exp=40", mem_req, mem_addr); end
        wait_for(3, 30, ok);
        checks++; if (!ok || pc !== 8'h40) begin errors++; $display("FAIL jump_halt ok=%b pc=%h exp=40", ok, pc); end
        load_en = 1'b0;
        pulse_start(1'b1);
        wait_for(1, 30, ok);
        wait_for(2, 30, ok);
        checks++; if (!ok || mem_addr !== 8'h01 || mem_req !== 1'b1) begin errors++; $display("FAIL noload_addr ok=%b addr=%h exp=01", ok, mem_addr); end
        wait_for(3, 30, ok);
        checks++; if (!ok || pc !== 8'h01) begin errors++; $display("FAIL noload_halt ok=%b pc=%h exp=01", ok, pc); end
    endtask

    task automatic test_illegal_nop;
        logic [7:0] fetched [$];
        bit   prev_req;
        int   ill_cnt, val_cnt, n;
        logic [7:0] ill_pc;
        bit   seq_ok;
        for (int i = 0; i < 5; i++) mem[i] = 10'h380;
        mem[5] = 10'h140;
        mem[6] = 10'h380;
        mem[7] = 10'h3C0;
        ack_delay = 0;
        pulse_start(1'b1);
        prev_req = 1'b0; ill_cnt = 0; val_cnt = 0; ill_pc = '0; n = 0;
        while (!halted && n < 200) begin
            if (mem_req && !prev_req) fetched.push_back(mem_addr);
            prev_req = mem_req;
            if (illegal_op) begin ill_cnt++; ill_pc = pc; end
            if (instr_valid) val_cnt++;
            n++;
            @(negedge clk);
        end
        seq_ok = (fetched.size() == 8);
        for (int i = 0; i < fetched.size() && i < 8; i++) if (fetched[i] !== 8'(i)) seq_ok = 1'b0;
        checks++; if (!seq_ok) begin errors++; $display("FAIL illegal_fetch_seq got_count=%0d exp=8 in order 0..7", fetched.size()); end
        checks++; if (ill_cnt != 1) begin errors++; $display("FAIL illegal_pulse_len got=%0d exp=1", ill_cnt); end
        checks++; if (ill_pc !== 8'h06) begin errors++; $display("FAIL illegal_pc got=%h exp=06", ill_pc); end
        checks++; if (val_cnt != 0) begin errors++; $display("FAIL illegal_no_valid got=%0d exp=0", val_cnt); end
        checks++; if (!halted || pc !== 8'h07) begin errors++; $display("FAIL illegal_halt halted=%b pc=%h exp=07", halted, pc); end
    endtask

    task automatic test_stop;
        bit ok;
        int vcnt, n;
        mem[0] = 10'h0C5;
        mem[1] = 10'h3C0;
        ack_delay = 4; exec_delay = 1;
        pulse_start(1'b1);
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        vcnt = 0; n = 0;
        while (busy && n < 60) begin if (instr_valid) vcnt++; n++; @(negedge clk); end
        checks++; if (busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL stop_idle busy=%b halted=%b exp 0 0", busy, halted); end
        checks++; if (vcnt != 2) begin errors++; $display("FAIL stop_exec_ran got=%0d exp=2", vcnt); end
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL stop_pc got=%h exp=01", pc); end
        ack_delay = 1;
        pulse_start(1'b0);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin errors++; $display("FAIL stop_resume req=%b addr=%h exp=01", mem_req, mem_addr); end
        wait_for(3, 30, ok);
        checks++; if (!ok || pc !== 8'h01) begin errors++; $display("FAIL stop_resume_halt ok=%b pc=%h exp=01", ok, pc); end
    endtask

    task automatic test_timeout;
        int vcnt, tcnt;
        bit halted_at_to;
        logic [7:0] pc_at_to;
        mem[0] = 10'h00A;
        mem[1] = 10'h3C0;
        exec_en = 1'b0;
        pulse_start(1'b1);
        vcnt = 0; tcnt = 0; halted_at_to = 1'b0; pc_at_to = 8'hxx;
        for (int i = 0; i < 45; i++) begin
            if (instr_valid) vcnt++;
            if (timeout) begin tcnt++; halted_at_to = halted; pc_at_to = pc; end
            @(negedge clk);
        end
        checks++; if (vcnt != 15) begin errors++; $display("FAIL to_exec_len got=%0d exp=15", vcnt); end
        checks++; if (tcnt != 1) begin errors++; $display("FAIL to_pulse_len got=%0d exp=1", tcnt); end
        checks++; if (halted_at_to !== 1'b1 || pc_at_to !== 8'h00) begin errors++; $display("FAIL to_halt halted=%b pc=%h exp 1 00", halted_at_to, pc_at_to); end
        exec_en = 1'b1; exec_delay = 14;
        pulse_start(1'b1);
        vcnt = 0; tcnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (instr_valid) vcnt++;
            if (timeout) tcnt++;
            @(negedge clk);
        end
        checks++; if (tcnt != 0) begin errors++; $display("FAIL to_edge_no_timeout got=%0d exp=0", tcnt); end
        checks++; if (vcnt != 15) begin errors++; $display("FAIL to_edge_exec_len got=%0d exp=15", vcnt); end
        checks++; if (!halted || pc !== 8'h01) begin errors++; $display("FAIL to_edge_halt halted=%b pc=%h exp=01", halted, pc); end
    endtask

    task automatic test_wrap_reset;
        bit ok;
        mem[0] = 10'h0AB;
        mem[8'hFF] = 10'h048;
        ack_delay = 1; exec_delay = 1; exec_en = 1'b1;
        load_en = 1'b1; load_pc = 8'h00; load_val = 8'hFF;
        pulse_start(1'b1);
        wait_addr = 8'hFF;
        wait_for(5, 40, ok);
        wait_for(1, 20, ok);
        checks++; if (!ok || instr !== 10'h048) begin errors++; $display("FAIL wrap_instr ok=%b got=%h exp=048", ok, instr); end
        wait_for(2, 20, ok);
        checks++; if (!ok || pc !== 8'h00 || mem_addr !== 8'h00) begin errors++; $display("FAIL wrap_pc ok=%b pc=%h exp=00", ok, pc); end
        wait_for(1, 20, ok);
        wait_for(2, 20, ok);
        wait_for(1, 20, ok);
        checks++; if (!ok || pc !== 8'hFF) begin errors++; $display("FAIL rst_setup ok=%b pc=%h exp=FF", ok, pc); end
        #1 rst = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || pc !== 8'h00 || mem_req !== 1'b0 || instr !== 10'h380)
            begin errors++; $display("FAIL rst_exec valid=%b pc=%h req=%b instr=%h exp 0 00 0 380", instr_valid, pc, mem_req, instr); end
        @(negedge clk);
        rst = 1'b1;
        load_en = 1'b0;
        ack_delay = 20;
        pulse_start(1'b0);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_fetch_setup req=%b exp=1", mem_req); end
        #1 rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_fetch req=%b busy=%b exp 0 0", mem_req, busy); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 10'h3C0;
        test_reset();
        test_basic();
        test_jump();
        test_illegal_nop();
        test_stop();
        test_timeout();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim time limit reached");
        $fatal(1, "time limit");
    end

endmodule
